multi_line_buffer: RTL and testbench

- Parametrised successor to the single-line pixel line memory.
- Stores NUM_TAPS-1 previous image lines in on-chip RAM banks.
- For every accepted input pixel, emits a vertical column of NUM_TAPS pixels at the same x position. Tap 0 is the current row; tap k is k rows above.
- Sits between the camera/pixel source and the window/pattern-matching stage. Adds valid/ready flow control, frame-start handling and row/column position outputs.

---
 rtl/multi_line_buffer_pkg.sv | 19 +
 rtl/multi_line_buffer_line_ram_bank.sv | 30 +++
 rtl/multi_line_buffer.sv | 133 +++++++++++++
 tb/tb_multi_line_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_line_buffer_pkg.sv
// Shared types, default widths and tap slicing helper for the multi-line buffer.
package multi_line_buffer_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_LINE_LEN = 1280;
  localparam int unsigned DEF_NUM_TAPS = 3;
  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_ROW_W    = 12;

  typedef logic [DEF_DATA_W-1:0] pixel_t;
  typedef logic [DEF_ADDR_W-1:0] col_t;
  typedef logic [DEF_ROW_W-1:0]  row_t;

  // LSB position of tap k inside the packed tap vector (tap 0 = newest row).
  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/multi_line_buffer_line_ram_bank.sv
// One line of pixel storage: single clock, one write port, one registered read port.
module line_ram_bank
  import multi_line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_LINE_LEN,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read-first synchronous read; read data holds while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-line buffer: emits a vertical column of NUM_TAPS pixels per accepted input pixel.
module multi_line_buffer
  import multi_line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LINE_LEN = DEF_LINE_LEN,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ROW_W    = DEF_ROW_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_TAPS*DATA_W-1:0]   out_taps,
  output logic [ADDR_W-1:0]            out_col,
  output logic [ROW_W-1:0]             out_row,
  output logic                         out_window_ok
);

  localparam int unsigned       NB       = NUM_TAPS - 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = '1;
  localparam logic [ROW_W-1:0]  ROW_OK   = ROW_W'(NUM_TAPS - 1);

  logic                       stall;
  logic                       accept;
  logic                       wr_en;
  logic [ADDR_W-1:0]          col_cnt;
  logic [ROW_W-1:0]           row_cnt;
  logic [ADDR_W-1:0]          cur_col;
  logic [ROW_W-1:0]           cur_row;
  logic                       s1_valid;
  logic [DATA_W-1:0]          s1_data;
  logic [ADDR_W-1:0]          s1_col;
  logic [ROW_W-1:0]           s1_row;
  logic [DATA_W-1:0]          rd_data [NB];
  logic [DATA_W-1:0]          wr_data [NB];
  logic [NUM_TAPS*DATA_W-1:0] taps_nxt;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign wr_en    = !stall && s1_valid;

  // A start-of-frame pixel is forced to the origin regardless of counter state.
  assign cur_col = in_sof ? '0 : col_cnt;
  assign cur_row = in_sof ? '0 : row_cnt;

  // Column/row position of the next pixel; row saturates at its maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (cur_col == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == ROW_MAX) ? cur_row : cur_row + ROW_W'(1);
      end else begin
        col_cnt <= cur_col + ADDR_W'(1);
        row_cnt <= cur_row;
      end
    end
  end

  // Stage 1: capture pixel and position alongside the RAM read of the same column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_col  <= cur_col;
        s1_row  <= cur_row;
      end
    end
  end

  assign taps_nxt[tap_lsb(0, DATA_W) +: DATA_W] = s1_data;

  // Bank cascade: bank 0 takes the new pixel, bank k takes what bank k-1 held.
  for (genvar k = 0; k < NB; k++) begin : g_bank
    if (k == 0) begin : g_first
      assign wr_data[k] = s1_data;
    end else begin : g_rest
      assign wr_data[k] = rd_data[k-1];
    end

    assign taps_nxt[tap_lsb(k + 1, DATA_W) +: DATA_W] = rd_data[k];

    line_ram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_LEN),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (s1_col),
      .wr_data (wr_data[k]),
      .rd_en   (accept),
      .rd_addr (cur_col),
      .rd_data (rd_data[k])
    );
  end

  // Stage 2: output register, frozen while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_taps      <= '0;
      out_col       <= '0;
      out_row       <= '0;
      out_window_ok <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_taps      <= taps_nxt;
        out_col       <= s1_col;
        out_row       <= s1_row;
        out_window_ok <= (s1_row >= ROW_OK);
      end
    end
  end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Self-checking bench for multi_line_buffer (LINE_LEN=4, NUM_TAPS=3, small row counter).
module tb_multi_line_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned LL = 4;
  localparam int unsigned NT = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned RW = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NT*DW-1:0]  out_taps;
  logic [AW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic              out_window_ok;

  multi_line_buffer #(
    .DATA_W   (DW),
    .LINE_LEN (LL),
    .NUM_TAPS (NT),
    .ADDR_W   (AW),
    .ROW_W    (RW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sof        (in_sof),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taps      (out_taps),
    .out_col       (out_col),
    .out_row       (out_row),
    .out_window_ok (out_window_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          sof;
    logic [DW-1:0] d;
    logic          exp_v;
    logic [AW-1:0] exp_col;
    logic [RW-1:0] exp_row;
    logic          exp_ok;
    logic          chk_taps;
    logic [23:0]   exp_taps;
  } vec_t;

  typedef struct {
    logic [AW-1:0] col;
    logic [RW-1:0] row;
    logic          ok;
    logic [23:0]   taps;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: pixels indexed by stream line number, outputs queued in order.
  logic [DW-1:0] hist [8][LL];
  exp_t          exp_q [$];
  int            m_col  = 0;
  int            m_line = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Called just before each rising edge: score the output handshake and model the input one.
  task automatic monitor();
    exp_t e;
    if (reset) begin
      exp_q.delete();
      m_col  = 0;
      m_line = 0;
      return;
    end
    check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out: got column col=%0d row=%0d want none", out_col, out_row);
      end else begin
        e = exp_q.pop_front();
        check("mdl_col", 32'(out_col), 32'(e.col));
        check("mdl_row", 32'(out_row), 32'(e.row));
        check("mdl_ok", 32'(out_window_ok), 32'(e.ok));
        check("mdl_tap0", 32'(out_taps[7:0]), 32'(e.taps[7:0]));
        if (e.ok) check("mdl_taps", 32'(out_taps), 32'(e.taps));
      end
    end
    if (in_valid && in_ready) begin
      if (in_sof) begin
        m_col  = 0;
        m_line = 0;
      end
      hist[m_line % 8][m_col] = in_data;
      e.col  = AW'(m_col);
      e.row  = (m_line > 15) ? 4'd15 : RW'(m_line);
      e.ok   = (m_line >= 2);
      e.taps = '0;
      for (int k = 0; k < 3; k++) begin
        if (m_line >= k) e.taps[k*8 +: 8] = hist[(m_line - k) % 8][m_col];
      end
      exp_q.push_back(e);
      m_col++;
      if (m_col == LL) begin
        m_col = 0;
        m_line++;
      end
    end
  endtask

  // Inputs are driven at posedge+1, bench checks at posedge+4, model at posedge+5.
  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int i);
    return DW'((i / 4) * 16 + (i % 4));
  endfunction

  vec_t vecs [18];
  int   n_acc;
  int   cyc;

  initial begin
    // Fill table: 4 rows of row*16+col, then two idle cycles to drain.
    for (int i = 0; i < 18; i++) begin
      int j, r, c;
      j = i - 2;
      r = j / 4;
      c = j % 4;
      vecs[i].v        = (i < 16);
      vecs[i].sof      = (i == 0);
      vecs[i].d        = (i < 16) ? pix(i) : 8'h00;
      vecs[i].exp_v    = (j >= 0) && (j < 16);
      vecs[i].exp_col  = (j >= 0) ? AW'(c) : '0;
      vecs[i].exp_row  = (j >= 0) ? RW'(r) : '0;
      vecs[i].exp_ok   = (j >= 0) && (r >= 2);
      vecs[i].chk_taps = (j >= 0) && (r >= 2);
      vecs[i].exp_taps = vecs[i].chk_taps ?
                         {8'((r - 2) * 16 + c), 8'((r - 1) * 16 + c), 8'(r * 16 + c)} : 24'h0;
    end

    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_taps", 32'(out_taps), 32'd0);
    check("rst_out_col", 32'(out_col), 32'd0);
    check("rst_out_row", 32'(out_row), 32'd0);
    check("rst_window_ok", 32'(out_window_ok), 32'd0);
    tick();
    reset = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Table-driven fill, latency and column wrap.
    for (int i = 0; i < 18; i++) begin
      in_valid = vecs[i].v;
      in_sof   = vecs[i].sof;
      in_data  = vecs[i].d;
      #3;
      check($sformatf("fill_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        check($sformatf("fill_col[%0d]", i), 32'(out_col), 32'(vecs[i].exp_col));
        check($sformatf("fill_row[%0d]", i), 32'(out_row), 32'(vecs[i].exp_row));
        check($sformatf("fill_ok[%0d]", i), 32'(out_window_ok), 32'(vecs[i].exp_ok));
        check($sformatf("fill_tap0[%0d]", i), 32'(out_taps[7:0]), 32'(vecs[i].d == 0 ? pix(i - 2) : pix(i - 2)));
        if (vecs[i].chk_taps)
          check($sformatf("fill_taps[%0d]", i), 32'(out_taps), 32'(vecs[i].exp_taps));
      end
      tick();
    end
    in_sof = 1'b0;

    // Backpressure at row 2 col 2 for five cycles.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = pix(i);
      tick();
    end
    in_sof = 1'b0; in_data = pix(12); out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #3;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_col", 32'(out_col), 32'd2);
      check("bp_row", 32'(out_row), 32'd2);
      check("bp_taps_hold", 32'(out_taps), 32'h021222);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 12; i < 20; i++) begin
      in_data = pix(i);
      #3;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();

    // Random bubbles and backpressure over one long frame (row counter saturates).
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 200 && cyc < 3000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sof    = (n_acc == 0) && in_valid;
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (in_valid && in_ready) n_acc++;
      tick();
      cyc++;
    end
    check("rand_accept_budget", 32'(n_acc), 32'd200);
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Mid-line start of frame at row 2 col 2.
    for (int i = 0; i < 24; i++) begin
      if (i < 22) begin
        in_valid = 1'b1;
        in_sof   = (i == 0) || (i == 10);
        in_data  = (i < 10) ? pix(i) : (8'h80 | pix(i - 10));
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      #3;
      if (i == 12) begin
        check("sof_col", 32'(out_col), 32'd0);
        check("sof_row", 32'(out_row), 32'd0);
        check("sof_ok", 32'(out_window_ok), 32'd0);
        check("sof_tap0", 32'(out_taps[7:0]), 32'h80);
      end
      if (i == 19) check("sof_row1_ok", 32'(out_window_ok), 32'd0);
      if (i == 20) begin
        check("sof_row2_ok", 32'(out_window_ok), 32'd1);
        check("sof_row2_row", 32'(out_row), 32'd2);
        check("sof_row2_taps", 32'(out_taps), 32'h8090A0);
      end
      tick();
    end

    // Reset mid-frame at row 1 col 1.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = pix(i);
      tick();
    end
    in_sof = 1'b0; in_data = pix(5);
    #2;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_taps", 32'(out_taps), 32'd0);
    check("mrst_col", 32'(out_col), 32'd0);
    check("mrst_row", 32'(out_row), 32'd0);
    check("mrst_ok", 32'(out_window_ok), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #3;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_data = 8'h78;
    tick();
    in_valid = 1'b0;
    #3;
    check("mrst_first_valid", 32'(out_valid), 32'd1);
    check("mrst_first_col", 32'(out_col), 32'd0);
    check("mrst_first_row", 32'(out_row), 32'd0);
    check("mrst_first_ok", 32'(out_window_ok), 32'd0);
    check("mrst_first_tap0", 32'(out_taps[7:0]), 32'h77);
    tick();
    repeat (3) tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
